// File: rtl/axil_cmd_seq.sv
// Single-command AXI4-Lite master: turns one cmd_* request into an AW/W/B or AR/R
// transaction and reports completion with a one-cycle rsp_valid pulse.
module axil_cmd_seq #(
  parameter int unsigned P_ADDR_WIDTH = 8,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_TIMEOUT    = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                      rsp_valid,
  output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [P_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [P_DATA_WIDTH-1:0]   m_wdata,
  output logic [P_DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [P_ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]                m_arprot,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [P_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp
);

  localparam int unsigned LP_CNT_W = (P_TIMEOUT < 2) ? 1 : $clog2(P_TIMEOUT);
  localparam logic [LP_CNT_W-1:0] LP_LIMIT = LP_CNT_W'(P_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWr, StWrB, StRdAr, StRdR, StRsp} state_e;

  state_e                    r_state, w_state_d;
  logic [P_ADDR_WIDTH-1:0]   r_addr, w_addr_d;
  logic [P_DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
  logic [P_DATA_WIDTH-1:0]   r_rdata, w_rdata_d;
  logic                      r_err, w_err_d;
  logic                      r_aw_done, w_aw_done_d;
  logic                      r_w_done, w_w_done_d;
  logic [LP_CNT_W-1:0]       r_cnt, w_cnt_d;
  logic                      w_expire, w_aw_hs, w_w_hs;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_wdata   <= w_wdata_d;
      r_rdata   <= w_rdata_d;
      r_err     <= w_err_d;
      r_aw_done <= w_aw_done_d;
      r_w_done  <= w_w_done_d;
      r_cnt     <= w_cnt_d;
    end
  end

  // Expiry fires in the cycle the counter would reach P_TIMEOUT.
  assign w_expire = (P_TIMEOUT != 0) && (r_cnt == LP_LIMIT);
  assign w_aw_hs  = m_awvalid && m_awready;
  assign w_w_hs   = m_wvalid && m_wready;

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_rdata_d   = r_rdata;
    w_err_d     = r_err;
    w_aw_done_d = r_aw_done;
    w_w_done_d  = r_w_done;
    w_cnt_d     = r_cnt;
    if (r_state != StIdle && r_state != StRsp) begin
      w_cnt_d = r_cnt + 1'b1;
    end
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          w_addr_d    = cmd_addr;
          w_wdata_d   = cmd_wdata;
          w_rdata_d   = '0;
          w_err_d     = 1'b0;
          w_aw_done_d = 1'b0;
          w_w_done_d  = 1'b0;
          w_cnt_d     = '0;
          w_state_d   = cmd_we ? StWr : StRdAr;
        end
      end
      StWr: begin
        if (w_aw_hs) w_aw_done_d = 1'b1;
        if (w_w_hs)  w_w_done_d  = 1'b1;
        if (w_expire) begin
          w_err_d   = 1'b1;
          w_state_d = StRsp;
        end else if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_d = StWrB;
        end
      end
      StWrB: begin
        // A response landing on the expiry cycle still completes normally.
        if (m_bvalid) begin
          w_err_d   = (m_bresp != 2'b00);
          w_state_d = StRsp;
        end else if (w_expire) begin
          w_err_d   = 1'b1;
          w_state_d = StRsp;
        end
      end
      StRdAr: begin
        if (w_expire) begin
          w_err_d   = 1'b1;
          w_state_d = StRsp;
        end else if (m_arready) begin
          w_state_d = StRdR;
        end
      end
      StRdR: begin
        if (m_rvalid) begin
          w_rdata_d = m_rdata;
          w_err_d   = (m_rresp != 2'b00);
          w_state_d = StRsp;
        end else if (w_expire) begin
          w_err_d   = 1'b1;
          w_state_d = StRsp;
        end
      end
      StRsp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // cmd_ready is gated by reset so it stays low while ARESET is held.
  assign cmd_ready = (r_state == StIdle) && !ARESET;
  assign m_awvalid = (r_state == StWr) && !r_aw_done;
  assign m_wvalid  = (r_state == StWr) && !r_w_done;
  assign m_bready  = (r_state == StWrB);
  assign m_arvalid = (r_state == StRdAr);
  assign m_rready  = (r_state == StRdR);
  assign rsp_valid = (r_state == StRsp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign m_awaddr  = r_addr;
  assign m_araddr  = r_addr;
  assign m_wdata   = r_wdata;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign m_wstrb   = {(P_DATA_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_axil_cmd_seq.sv
// Directed bench for axil_cmd_seq: scripted AXI4-Lite slave behaviour, expected
// responses queued at issue time and checked by an independent rsp_valid monitor.
module tb_axil_cmd_seq;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_awvalid, m_awready = 1'b0;
  logic [7:0]  m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 1'b0, m_bready;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_arvalid, m_arready = 1'b0;
  logic [7:0]  m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid = 1'b0, m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;

  axil_cmd_seq #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(32), .P_TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge ACLK) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_rsp: got rdata %h err %b expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Called just after a negedge; returns at the negedge of the first busy cycle.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wd);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0;
  endtask

  initial begin
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_outs", {25'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid,
                     rsp_err}, 32'd0);
    chk("rst_wstrb_prot", {25'd0, m_wstrb, m_awprot}, {25'd0, 4'hF, 3'b000});
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Write with AW and W accepted together, B two cycles later.
    issue(1'b1, 8'h04, 32'hDEADBEEF);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    chk("w1_valids", {30'd0, m_awvalid, m_wvalid}, 32'd3);
    chk("w1_awaddr", 32'(m_awaddr), 32'h04);
    chk("w1_wdata", m_wdata, 32'hDEADBEEF);
    chk("w1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge ACLK);
    chk("w1_valids_drop", {30'd0, m_awvalid, m_wvalid}, 32'd0);
    chk("w1_bready", 32'(m_bready), 32'd1);
    m_awready = 1'b0; m_wready = 1'b0;
    @(negedge ACLK);
    chk("w1_bready_hold", 32'(m_bready), 32'd1);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge ACLK);
    m_bvalid = 1'b0;
    chk("w1_bready_rsp", 32'(m_bready), 32'd0);
    @(negedge ACLK);

    // Write with W accepted three cycles before AW; B held two cycles.
    issue(1'b1, 8'h10, 32'h12345678);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    m_wready = 1'b1;
    @(negedge ACLK);
    m_wready = 1'b0;
    chk("w2_w_drop", {30'd0, m_awvalid, m_wvalid}, 32'd2);
    @(negedge ACLK);
    chk("w2_aw_hold1", 32'(m_awvalid), 32'd1);
    @(negedge ACLK);
    chk("w2_aw_hold2", {30'd0, m_awvalid, m_wvalid}, 32'd2);
    m_awready = 1'b1;
    @(negedge ACLK);
    m_awready = 1'b0;
    chk("w2_aw_drop", {30'd0, m_awvalid, m_bready}, 32'd1);
    m_bvalid = 1'b1;
    @(negedge ACLK);
    chk("w2_bready_off", 32'(m_bready), 32'd0);
    @(negedge ACLK);
    m_bvalid = 1'b0;
    @(negedge ACLK);

    // Read returning SLVERR data.
    issue(1'b0, 8'h08, 32'h0);
    exp_q.push_back('{rdata: 32'h000000A5, err: 1'b1});
    chk("r1_arvalid", 32'(m_arvalid), 32'd1);
    chk("r1_araddr", 32'(m_araddr), 32'h08);
    m_arready = 1'b1;
    @(negedge ACLK);
    m_arready = 1'b0;
    chk("r1_rready", {30'd0, m_arvalid, m_rready}, 32'd1);
    m_rvalid = 1'b1; m_rdata = 32'h000000A5; m_rresp = 2'b10;
    @(negedge ACLK);
    m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    @(negedge ACLK);

    // Write with AW first, then W, SLVERR on B; rdata must read back as zero.
    issue(1'b1, 8'h14, 32'hCAFEF00D);
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    m_awready = 1'b1;
    @(negedge ACLK);
    m_awready = 1'b0;
    chk("w3_aw_drop", {30'd0, m_awvalid, m_wvalid}, 32'd1);
    m_wready = 1'b1;
    @(negedge ACLK);
    m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10;
    @(negedge ACLK);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    @(negedge ACLK);

    // Stray B/R responses while idle must not produce anything.
    m_bvalid = 1'b1; m_rvalid = 1'b1;
    repeat (3) @(negedge ACLK);
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    chk("stray_idle_ready", 32'(cmd_ready), 32'd1);

    // Read timeout: arready never comes.
    issue(1'b0, 8'h0C, 32'h0);
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("to_arvalid_%0d", i), 32'(m_arvalid), 32'd1);
      chk($sformatf("to_no_rsp_%0d", i), 32'(rsp_valid), 32'd0);
      @(negedge ACLK);
    end
    chk("to_rsp_valid", {30'd0, rsp_valid, m_arvalid}, 32'd2);
    @(negedge ACLK);

    // Reset while waiting for B drops the command silently.
    issue(1'b1, 8'h30, 32'h0BADF00D);
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge ACLK);
    m_awready = 1'b0; m_wready = 1'b0;
    chk("rst_in_wrb", 32'(m_bready), 32'd1);
    #2 ARESET = 1'b1;
    #1;
    chk("async_rst_outs", {23'd0, cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid,
                           m_rready, rsp_valid, rsp_err}, 32'd0);
    chk("async_rst_rdata", rsp_rdata, 32'd0);
    m_bvalid = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    m_bvalid = 1'b0;
    ARESET = 1'b0;
    #1;
    chk("release_ready", 32'(cmd_ready), 32'd1);
    issue(1'b0, 8'h20, 32'h0);
    exp_q.push_back('{rdata: 32'h00000055, err: 1'b0});
    chk("r2_araddr", 32'(m_araddr), 32'h20);
    m_arready = 1'b1;
    @(negedge ACLK);
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h00000055;
    @(negedge ACLK);
    m_rvalid = 1'b0; m_rdata = 32'h0;
    repeat (4) @(negedge ACLK);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_cmd_seq.md
AXIL_CMD_SEQ -- requirements
Module: axil_cmd_seq

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 8: AXI4-Lite address width.
REQ-002 SHALL have parameter P_DATA_WIDTH, default 32: AXI4-Lite data width.
REQ-003 SHALL have parameter P_TIMEOUT, default 256: cycle limit per command; 0 disables the limit.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: ACLK  in  1  rising-edge clock.
REQ-005 SHALL have ARESET  in  1  asynchronous active-high reset.
REQ-006 SHALL have cmd_valid  in  1  command request.
REQ-007 SHALL have cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 SHALL have cmd_we  in  1  1=write, 0=read.
REQ-009 SHALL have cmd_addr  in  P_ADDR_WIDTH  target register address.
REQ-010 SHALL have cmd_wdata  in  P_DATA_WIDTH  write data.
REQ-011 SHALL have rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have rsp_rdata  out  P_DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-013 SHALL have rsp_err  out  1  nonzero BRESP/RRESP or timeout.
REQ-014 SHALL have m_awvalid  out  1;  m_awready  in  1;  m_awaddr  out  P_ADDR_WIDTH.
REQ-015 SHALL have m_awprot  out  3  constant 3'b000.
REQ-016 SHALL have m_wvalid  out  1;  m_wready  in  1;  m_wdata  out  P_DATA_WIDTH.
REQ-017 SHALL have m_wstrb  out  P_DATA_WIDTH/8  constant all ones.
REQ-018 SHALL have m_bvalid  in  1;  m_bready  out  1;  m_bresp  in  2.
REQ-019 SHALL have m_arvalid  out  1;  m_arready  in  1;  m_araddr  out  P_ADDR_WIDTH.
REQ-020 SHALL have m_arprot  out  3  constant 3'b000.
REQ-021 SHALL have m_rvalid  in  1;  m_rready  out  1;  m_rdata  in  P_DATA_WIDTH;  m_rresp  in  2.

Function
REQ-022 SHALL implement FSM states IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready it SHALL latch we/addr/wdata and enter WR or RD_AR.
REQ-024 SHALL assert m_awvalid and m_wvalid together in the cycle after acceptance (latency 1), with m_awaddr/m_wdata held stable.
REQ-025 SHALL deassert m_awvalid and m_wvalid independently, each in the cycle after its own handshake; AW-before-W, W-before-AW and same-cycle SHALL all be supported.
REQ-026 SHALL enter WR_B once both handshakes are done, hold m_bready=1 there, and on m_bvalid capture rsp_err=(m_bresp!=0) and enter RSP.
REQ-027 SHALL hold m_arvalid in RD_AR until m_arready, then enter RD_R.
REQ-028 In RD_R it SHALL hold m_rready=1, and on m_rvalid capture rsp_rdata=m_rdata and rsp_err=(m_rresp!=0), then enter RSP.
REQ-029 SHALL never deassert a valid before its handshake, except on timeout.
REQ-030 SHALL pulse rsp_valid for exactly one cycle in RSP and return to IDLE; back-to-back commands are spaced by at least one IDLE cycle.
REQ-031 Timeout counter SHALL clear on acceptance and increment each non-IDLE, non-RSP cycle.
REQ-032 If P_TIMEOUT!=0 and the counter reaches P_TIMEOUT, it SHALL drop all m_* valid/ready signals, set rsp_err=1 and rsp_rdata=0, and enter RSP.
REQ-033 A response handshake coinciding with timeout expiry SHALL take priority: normal completion.
REQ-034 m_bvalid/m_rvalid SHALL be ignored outside WR_B/RD_R.

Reset
REQ-035 ARESET high SHALL immediately force IDLE, clear all m_* valid/ready, cmd_ready, rsp_valid, rsp_rdata, rsp_err and the counter; an in-flight command SHALL be dropped without a response; cmd_ready SHALL be 1 in the first cycle after release.

Verification
REQ-036 Write 0x04/0xDEADBEEF, slave awready+wready same cycle, bvalid 2 cycles later with OKAY -> one rsp_valid pulse, rsp_err=0, rsp_rdata=0.
REQ-037 Write with wready 3 cycles before awready -> m_wvalid drops after the W handshake, m_awvalid holds until its own handshake, exactly one B accepted.
REQ-038 Read 0x08, slave returns 0x0000_00A5 with RRESP=2'b10 -> rsp_rdata=0xA5, rsp_err=1.
REQ-039 P_TIMEOUT=16, slave never asserts arready -> m_arvalid drops and rsp_valid with rsp_err=1 appears 16 cycles after acceptance.
REQ-040 ARESET asserted while in WR_B -> all outputs 0 asynchronously, no rsp_valid; after release a read completes normally.
